// File: rtl/pll_lock_supervisor_if.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor_if
//
// Groups the PLL-facing and downstream-facing signals of the PLL lock
// supervisor so they travel as one bundle.
//
//   locked_in  PLL lock indication, asynchronous to refclk
//   restart    synchronous pulse requesting a full re-sequence
//   pll_rst    active-high reset to the PLL
//   sys_rst_n  downstream reset, asynchronous assert / synchronous deassert
//   ready      high only while the supervisor is in RUN
//   fail       high only while the supervisor is in FAIL
//   retry_cnt  lock timeouts since the last RUN or restart
//   loss_cnt   loss-of-lock events, saturating at 255
//   state      current sequencer state
//
// Modports:
//   master  the supervisor side (drives resets and status)
//   slave   the environment side (drives lock and restart)
// -----------------------------------------------------------------------------
interface pll_lock_supervisor_if;
    logic       locked_in;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    modport master (
        input  locked_in,
        input  restart,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fail,
        output retry_cnt,
        output loss_cnt,
        output state
    );

    modport slave (
        output locked_in,
        output restart,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  loss_cnt,
        input  state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the on-chip PLL from power-up to a usable clock: pulses the PLL
// reset, waits for lock, qualifies lock as stable, then releases the
// downstream system reset. Loss of lock in RUN restarts the sequence; repeated
// lock timeouts end in FAIL until restart or rst_n.
//
// Ports:
//   refclk  reference clock (also the PLL input clock)
//   rst_n   asynchronous active-low reset
//   sup     pll_lock_supervisor_if.master: locked_in, restart in;
//           pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt, state out
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge that the state register does.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int LOSS_FILTER   = 4
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master sup
);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // The shared counter only ever counts up to (largest parameter - 1).
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

    logic             lock_sync_p0;
    logic             lock_sync_p1;
    logic             lock_s;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       retry_q;
    logic [7:0]       retry_nxt;
    logic [7:0]       loss_q;
    logic [7:0]       loss_nxt;

    logic             pll_rst_q;
    logic             sys_rst_n_q;
    logic             ready_q;
    logic             fail_q;

    // ---- stage p0/p1: two-flop synchronizer for the asynchronous lock ----
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
        end else begin
            lock_sync_p0 <= sup.locked_in;
            lock_sync_p1 <= lock_sync_p0;
        end
    end

    assign lock_s = lock_sync_p1;

    // ---- next-state decision ----
    // The counter counts cycles in RST_PLL and WAIT_LOCK, consecutive locked
    // samples in STABLE and consecutive unlocked samples in RUN. RUN is
    // entered after STABLE_CYCLES consecutive lock_s=1 samples taken in STABLE.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        retry_nxt = retry_q;
        loss_nxt  = loss_q;

        if (sup.restart) begin
            // Restart outranks any timeout or loss decided on this cycle.
            state_nxt = RST_PLL;
            cnt_nxt   = '0;
            retry_nxt = 8'd0;
        end else begin
            unique case (state_q)
                RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_nxt = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_nxt = FAIL;
                        end else begin
                            state_nxt = RST_PLL;
                            retry_nxt = retry_q + 8'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        retry_nxt = 8'd0;
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        cnt_nxt = '0;
                    end else if (cnt_q == LOSS_LAST) begin
                        state_nxt = RST_PLL;
                        cnt_nxt   = '0;
                        if (loss_q != 8'hFF) begin
                            loss_nxt = loss_q + 8'd1;
                        end
                    end
                end
                FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---- state and registered outputs ----
    // sys_rst_n resets asynchronously with rst_n and only rises on an edge,
    // giving asynchronous assert / synchronous deassert downstream.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            retry_q     <= retry_nxt;
            loss_q      <= loss_nxt;
            pll_rst_q   <= (state_nxt == RST_PLL) || (state_nxt == FAIL);
            sys_rst_n_q <= (state_nxt == RUN);
            ready_q     <= (state_nxt == RUN);
            fail_q      <= (state_nxt == FAIL);
        end
    end

    assign sup.pll_rst   = pll_rst_q;
    assign sup.sys_rst_n = sys_rst_n_q;
    assign sup.ready     = ready_q;
    assign sup.fail      = fail_q;
    assign sup.retry_cnt = retry_q;
    assign sup.loss_cnt  = loss_q;
    assign sup.state     = state_q;

endmodule
